// File: rtl/fadd_norm_stage_pkg.sv
// Shared floating-point adder definitions: default widths, hidden-bit position
// and the beat payload passed between adder stages.
package fadd_norm_stage_pkg;

  localparam int unsigned FADD_EXP_W  = 8;
  localparam int unsigned FADD_MANT_W = 32;
  localparam int unsigned HID_POS     = 30;
  localparam int unsigned EXP_MAX     = (1 << FADD_EXP_W) - 1;

  typedef struct packed {
    logic                   sign;
    logic [FADD_EXP_W-1:0]  exp;
    logic [FADD_MANT_W-1:0] mant;
  } fadd_beat_t;

endpackage

// File: rtl/fadd_norm_stage_penc32.sv
// 32-bit leading-one priority encoder: index of the most significant set bit
// plus an all-zero flag.
module penc32 (
  input  logic [31:0] req_i,
  output logic [4:0]  idx_o,
  output logic        zero_o
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    idx_o  = 5'd0;
    zero_o = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (req_i[i]) begin
        idx_o  = 5'(i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fadd_norm_stage.sv
// Post-add normalization: locates the leading one of the raw magnitude, shifts
// it to the hidden-bit position and adjusts the exponent, with zero/uf/of flags.
module fadd_norm_stage
  import fadd_norm_stage_pkg::*;
#(
  parameter int unsigned EXP_W  = FADD_EXP_W,
  parameter int unsigned MANT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_uf,
  output logic              out_of
);

  localparam int unsigned ESW = EXP_W + 2;
  localparam logic signed [ESW-1:0] E_MAX_S  = ESW'((1 << EXP_W) - 1);
  localparam logic signed [ESW-1:0] E_ZERO_S = '0;

  if (MANT_W != 32) begin : g_mant_w_chk
    $error("fadd_norm_stage: MANT_W must be 32 to match penc32");
  end

  logic              s1_valid_q;
  logic              s1_sign_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [MANT_W-1:0] s1_mant_q;
  logic              s2_valid_q;

  logic              s1_adv_c;
  logic              in_fire_c;

  logic [4:0]        enc_idx;
  logic              enc_zero;

  logic signed [ESW-1:0] exp_s;
  logic signed [ESW-1:0] e_c;
  logic [4:0]            sh_c;

  logic              sign_d;
  logic [EXP_W-1:0]  exp_d;
  logic [MANT_W-1:0] mant_d;
  logic              zero_d;
  logic              uf_d;
  logic              of_d;

  assign s1_adv_c  = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s1_adv_c;
  assign in_fire_c = in_valid && in_ready;
  assign out_valid = s2_valid_q;

  penc32 u_penc (
    .req_i  (s1_mant_q),
    .idx_o  (enc_idx),
    .zero_o (enc_zero)
  );

  assign exp_s = $signed({2'b00, s1_exp_q});

  // Shift/exponent adjust, then zero > overflow > underflow resolution.
  always_comb begin
    sh_c   = 5'd0;
    e_c    = exp_s;
    sign_d = s1_sign_q;
    mant_d = s1_mant_q;
    zero_d = 1'b0;
    uf_d   = 1'b0;
    of_d   = 1'b0;

    if (enc_idx == 5'd31) begin
      mant_d = {1'b0, s1_mant_q[MANT_W-1:2], s1_mant_q[1] | s1_mant_q[0]};
      e_c    = exp_s + $signed(ESW'(1));
    end else begin
      sh_c   = 5'(HID_POS) - enc_idx;
      mant_d = s1_mant_q << sh_c;
      e_c    = exp_s - $signed(ESW'(sh_c));
    end

    exp_d = e_c[EXP_W-1:0];

    if (enc_zero) begin
      mant_d = '0;
      exp_d  = '0;
      sign_d = 1'b0;
      zero_d = 1'b1;
    end else if (e_c >= E_MAX_S) begin
      exp_d  = '1;
      mant_d = '0;
      of_d   = 1'b1;
    end else if (e_c <= E_ZERO_S) begin
      exp_d  = '0;
      mant_d = '0;
      uf_d   = 1'b1;
      zero_d = 1'b1;
    end
  end

  // Stage 1: capture the incoming beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_fire_c) begin
        s1_sign_q <= in_sign;
        s1_exp_q  <= in_exp;
        s1_mant_q <= in_mant;
      end
    end
  end

  // Stage 2: registered normalized result, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_mant   <= '0;
      out_zero   <= 1'b0;
      out_uf     <= 1'b0;
      out_of     <= 1'b0;
    end else if (s1_adv_c) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign <= sign_d;
        out_exp  <= exp_d;
        out_mant <= mant_d;
        out_zero <= zero_d;
        out_uf   <= uf_d;
        out_of   <= of_d;
      end
    end
  end

endmodule

// File: tb/tb_fadd_norm_stage.sv
// Directed bench for fadd_norm_stage: reset, normalization cases, flag
// boundaries, mid-flight reset and a stalled back-to-back stream.
module tb_fadd_norm_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [31:0] out_mant;
  logic        out_zero;
  logic        out_uf;
  logic        out_of;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  fadd_norm_stage #(.EXP_W(8), .MANT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_uf    (out_uf),
    .out_of    (out_of)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic v, input logic s, input logic [7:0] e,
                                     input logic [31:0] m, input logic z, input logic u,
                                     input logic o);
    return 64'({v, s, e, m, z, u, o});
  endfunction

  function automatic logic [63:0] obs();
    return pk(out_valid, out_sign, out_exp, out_mant, out_zero, out_uf, out_of);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One isolated beat: nothing at 1 cycle, exact result at 2 cycles.
  task automatic send_check(input string tag, input logic s, input logic [7:0] e,
                            input logic [31:0] m, input logic [63:0] expv);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    check(tag, obs(), expv);
  endtask

  logic        st_s [6];
  logic [7:0]  st_e [6];
  logic [31:0] st_m [6];
  logic [63:0] st_x [6];
  int          tx, rx, cnt;
  logic        stalled_prev;
  logic [63:0] prev_obs;
  logic        rdy_pat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sign   = 1'b1;
    in_exp    = 8'h7F;
    in_mant   = 32'h8000_0003;
    out_ready = 1'b1;

    // Reset held with a valid beat offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outs", obs(), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(1));
    end

    @(negedge clk);
    rst_n    = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h7F;
    in_mant  = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_reset_lat1", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("post_reset_first", obs(), pk(1, 0, 8'h7F, 32'h4000_0000, 0, 0, 0));
    @(negedge clk);
    check("post_reset_drain", 64'(out_valid), 64'(0));

    send_check("carry_sticky", 0, 8'h7F, 32'h8000_0003, pk(1, 0, 8'h80, 32'h4000_0001, 0, 0, 0));
    send_check("left_p8",      0, 8'h7F, 32'h0000_0100, pk(1, 0, 8'h69, 32'h4000_0000, 0, 0, 0));
    send_check("uf_neg14",     1, 8'h10, 32'h0000_0001, pk(1, 1, 8'h00, 32'h0000_0000, 1, 1, 0));
    send_check("zero_sign",    1, 8'h55, 32'h0000_0000, pk(1, 0, 8'h00, 32'h0000_0000, 1, 0, 0));
    send_check("of_carry",     0, 8'hFE, 32'hC000_0000, pk(1, 0, 8'hFF, 32'h0000_0000, 0, 0, 1));
    send_check("uf_e0",        1, 8'h00, 32'h4000_0000, pk(1, 1, 8'h00, 32'h0000_0000, 1, 1, 0));
    send_check("max_normal",   0, 8'hFE, 32'h4000_0000, pk(1, 0, 8'hFE, 32'h4000_0000, 0, 0, 0));
    send_check("carry_to_fe",  1, 8'hFD, 32'h8000_0000, pk(1, 1, 8'hFE, 32'h4000_0000, 0, 0, 0));
    send_check("exp0_carry",   0, 8'h00, 32'h8000_0001, pk(1, 0, 8'h01, 32'h4000_0001, 0, 0, 0));
    send_check("min_normal",   0, 8'h1F, 32'h0000_0001, pk(1, 0, 8'h01, 32'h4000_0000, 0, 0, 0));
    send_check("of_exp_ff",    1, 8'hFF, 32'h4000_0000, pk(1, 1, 8'hFF, 32'h0000_0000, 0, 0, 1));

    // Reset while a beat sits in stage 1 must discard it.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h40;
    in_mant  = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midop_reset_outs", obs(), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midop_no_ghost", 64'(out_valid), 64'(0));
    end

    st_s[0] = 0; st_e[0] = 8'h7F; st_m[0] = 32'h4000_0000; st_x[0] = pk(1, 0, 8'h7F, 32'h4000_0000, 0, 0, 0);
    st_s[1] = 1; st_e[1] = 8'h80; st_m[1] = 32'h8000_0000; st_x[1] = pk(1, 1, 8'h81, 32'h4000_0000, 0, 0, 0);
    st_s[2] = 0; st_e[2] = 8'h20; st_m[2] = 32'h0001_0000; st_x[2] = pk(1, 0, 8'h12, 32'h4000_0000, 0, 0, 0);
    st_s[3] = 1; st_e[3] = 8'h05; st_m[3] = 32'h0000_0002; st_x[3] = pk(1, 1, 8'h00, 32'h0000_0000, 1, 1, 0);
    st_s[4] = 0; st_e[4] = 8'h01; st_m[4] = 32'h6000_0000; st_x[4] = pk(1, 0, 8'h01, 32'h6000_0000, 0, 0, 0);
    st_s[5] = 0; st_e[5] = 8'hFF; st_m[5] = 32'h0040_0000; st_x[5] = pk(1, 0, 8'hF7, 32'h4000_0000, 0, 0, 0);

    tx = 0;
    rx = 0;
    stalled_prev = 1'b0;
    prev_obs = '0;
    for (int cyc = 0; cyc < 80 && rx < 6; cyc++) begin
      @(negedge clk);
      rdy_pat   = ((cyc % 3) == 0);
      out_ready = rdy_pat;
      in_valid  = (tx < 6);
      if (tx < 6) begin
        in_sign = st_s[tx];
        in_exp  = st_e[tx];
        in_mant = st_m[tx];
      end
      #1;
      cnt = tx - rx;
      check("stream_in_ready", 64'(in_ready), 64'(!(cnt == 2 && !rdy_pat)));
      if (stalled_prev) check("stream_hold", obs(), prev_obs);
      if (out_valid && rdy_pat) begin
        if (rx < 6) check("stream_beat", obs(), st_x[rx]);
        else        check("stream_extra", 64'(rx), 64'(5));
        rx++;
      end
      if (in_valid && in_ready) tx++;
      stalled_prev = out_valid && !rdy_pat;
      prev_obs     = obs();
    end
    check("stream_count", 64'(rx), 64'(6));
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    check("stream_drained", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fadd_norm_stage.md
Name: fadd_norm_stage

Overview:
- Post-add normalization stage of the floating-point adder datapath.
- Consumes the raw 32-bit magnitude from the add/subtract stage, with sign and pre-normalization exponent.
- Uses the 32-bit leading-one priority encoder to find the MSB, then shifts the magnitude so the hidden bit lands at bit 30 and adjusts the exponent.
- Two-stage pipeline with valid/ready handshake; feeds the rounding stage.

Parameters:
- EXP_W, 8, exponent width (biased); 2^EXP_W-1 is the Inf/NaN code.
- MANT_W, 32, magnitude width; fixed at 32 to match the 32-bit priority encoder; any other value is a synthesis error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  biased exponent, aligned so the hidden bit is nominally at bit 30.
- in_mant  in  32  raw magnitude; bit 31 = add carry, bits 1:0 = guard/sticky.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  sign, passed through; forced 0 on a zero result.
- out_exp  out  EXP_W  normalized exponent.
- out_mant  out  32  normalized magnitude; bit 31 = 0, bit 30 = hidden 1 unless zero/flush.
- out_zero  out  1  result is exact zero.
- out_uf  out  1  underflow, flushed to zero.
- out_of  out  1  overflow, saturated to Inf.

Behaviour:
- Clock and reset: single clock clk. Asynchronous active-low reset rst_n clears both stage valid bits and all output registers to 0. Every output is 0 during reset except in_ready.
- Reset mid-operation drops all in-flight beats. No beat may emerge after reset deassertion unless it is newly accepted.
- Handshake: a beat transfers when valid && ready on the same edge.
- Pipeline advance: s1 advances when !s2_valid || out_ready. in_ready = !s1_valid || s1_advance, a combinational chain back from out_ready.
- Full throughput is one beat per cycle. Data is held stable while out_valid && !out_ready.
- Latency is exactly 2 cycles from accept to out_valid when unstalled.
- Stage 1: registers sign, exp, mant. Instantiates the encoder on the registered mant to produce the MSB index p[4:0] and the all-zero flag z. Registers p and z alongside the data into stage 2.
- Stage 2 normalize, with signed exponent arithmetic at EXP_W+2 bits:
  - z=1: mant=0, exp=0, sign=0, out_zero=1.
  - p=31: mant = {1'b0, mant[31:2], mant[1]|mant[0]} (right shift by 1, sticky OR preserved); e = exp+1.
  - p=30: pass through unchanged; e = exp.
  - p<30: mant = mant << (30-p); e = exp-(30-p).
- Post-checks, in priority order after the zero case:
  - e >= 2^EXP_W-1: exp = all ones, mant = 0, out_of=1.
  - e <= 0: exp=0, mant=0, out_uf=1, out_zero=1. Sign is kept.
  - Otherwise exp = e[EXP_W-1:0].
- Flags are one-hot-or-zero, except that uf implies zero.
- Simultaneous accept and emit in the same cycle is legal and loses no beat.
- Input exp = 0 with a nonzero mant follows the same arithmetic. No denormals are produced.

Decomposition:
- Shared fadd package holds:
  - EXP_W default;
  - hidden-bit position constant HID_POS=30;
  - EXP_MAX = 2^EXP_W-1;
  - a packed struct {sign, exp, mant} used between adder stages.
- One sub-module instance: the existing 32-bit priority encoder (PENC32), instantiated unchanged in stage 1.
- The shifter and exponent adjust stay inline in stage 2.

Test Plan:
- Reset with in_valid=1 held for 3 cycles -> out_valid=0 and all outputs 0. First beat emerges 2 cycles after rst_n rises.
- in_mant=0x8000_0003, exp=0x7F -> out_mant=0x4000_0001, exp=0x80, flags 0.
- in_mant=0x0000_0100 (p=8), exp=0x7F -> out_mant=0x4000_0000, exp=0x69.
- in_mant=0x0000_0001, exp=0x10 -> e=-14: out_uf=1, out_zero=1, mant=0, exp=0. Separately, in_mant=0, sign=1 -> out_zero=1, sign=0.
- in_mant=0xC000_0000, exp=0xFE -> out_of=1, exp=0xFF, mant=0.
- Stream 6 back-to-back beats with out_ready toggling 1,0,0,1… -> all 6 emerge in order, no loss or duplication, in_ready drops only when both stages are full and stalled, and outputs stay stable while stalled.
